// File: rtl/grid_env_pkg.sv
// rtl/grid_env_pkg.sv - shared types, action table and address packing for the grid environment stepper
package grid_env_pkg;

  localparam int GRID_COORD_W = 3;
  localparam int GRID_ACT_W   = 3;

  localparam logic [GRID_ACT_W-1:0] ACT_WEST  = 3'd0;
  localparam logic [GRID_ACT_W-1:0] ACT_NW    = 3'd1;
  localparam logic [GRID_ACT_W-1:0] ACT_NORTH = 3'd2;
  localparam logic [GRID_ACT_W-1:0] ACT_NE    = 3'd3;
  localparam logic [GRID_ACT_W-1:0] ACT_EAST  = 3'd4;
  localparam logic [GRID_ACT_W-1:0] ACT_SE    = 3'd5;
  localparam logic [GRID_ACT_W-1:0] ACT_SOUTH = 3'd6;
  localparam logic [GRID_ACT_W-1:0] ACT_SW    = 3'd7;

  localparam logic [31:0] R_WALL = 32'hC37F0000;
  localparam logic [31:0] R_GOAL = 32'h437F0000;

  typedef enum logic [1:0] {D_ZERO = 2'b00, D_POS = 2'b01, D_NEG = 2'b11} dir_e;

  typedef enum logic [1:0] {IDLE, ISSUE, CAP, OUT} state_e;

  function automatic dir_e act_dx(input logic [GRID_ACT_W-1:0] a);
    case (a)
      ACT_WEST, ACT_NW, ACT_SW: act_dx = D_NEG;
      ACT_NE, ACT_EAST, ACT_SE: act_dx = D_POS;
      default:                  act_dx = D_ZERO;
    endcase
  endfunction

  function automatic dir_e act_dy(input logic [GRID_ACT_W-1:0] a);
    case (a)
      ACT_NW, ACT_NORTH, ACT_NE: act_dy = D_NEG;
      ACT_SE, ACT_SOUTH, ACT_SW: act_dy = D_POS;
      default:                   act_dy = D_ZERO;
    endcase
  endfunction

  function automatic logic [2*GRID_COORD_W+GRID_ACT_W-1:0] pack_addr(
    input logic [GRID_COORD_W-1:0] x,
    input logic [GRID_COORD_W-1:0] y,
    input logic [GRID_ACT_W-1:0]   a
  );
    pack_addr = {x, y, a};
  endfunction

endpackage

// File: rtl/grid_move.sv
// rtl/grid_move.sv - combinational one-step move with per-axis wall clamping
module grid_move
  import grid_env_pkg::*;
#(
  parameter int COORD_W = 3
) (
  input  logic [COORD_W-1:0]    x_i,
  input  logic [COORD_W-1:0]    y_i,
  input  logic [GRID_ACT_W-1:0] action_i,
  output logic [COORD_W-1:0]    next_x_o,
  output logic [COORD_W-1:0]    next_y_o,
  output logic                  wall_o
);

  localparam logic [COORD_W-1:0] EDGE_MAX = {COORD_W{1'b1}};

  dir_e dx, dy;
  logic wall_x, wall_y;

  assign dx = act_dx(action_i);
  assign dy = act_dy(action_i);

  // A blocked axis keeps its coordinate while the other axis may still move.
  always_comb begin
    next_x_o = x_i;
    wall_x   = 1'b0;
    if (dx == D_POS) begin
      if (x_i == EDGE_MAX) wall_x = 1'b1;
      else                 next_x_o = x_i + 1'b1;
    end else if (dx == D_NEG) begin
      if (x_i == '0) wall_x = 1'b1;
      else           next_x_o = x_i - 1'b1;
    end
  end

  always_comb begin
    next_y_o = y_i;
    wall_y   = 1'b0;
    if (dy == D_POS) begin
      if (y_i == EDGE_MAX) wall_y = 1'b1;
      else                 next_y_o = y_i + 1'b1;
    end else if (dy == D_NEG) begin
      if (y_i == '0) wall_y = 1'b1;
      else           next_y_o = y_i - 1'b1;
    end
  end

  assign wall_o = wall_x | wall_y;

endmodule

// File: rtl/grid_env_stepper.sv
// rtl/grid_env_stepper.sv - action -> reward ROM read -> transition record; optional STEP_TIMEOUT_EN ends episodes at MAX_STEPS
module grid_env_stepper
  import grid_env_pkg::*;
#(
  parameter int COORD_W    = 3,
  parameter int ACT_W      = 3,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int START_X    = 0,
  parameter int START_Y    = 0,
  parameter int GOAL_X     = 7,
  parameter int GOAL_Y     = 7,
  parameter int MAX_STEPS  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_act_valid,
  output logic                  o_act_ready,
  input  logic [ACT_W-1:0]      i_action,
  output logic [ADDR_WIDTH-1:0] o_rt_addr,
  output logic                  o_rt_read,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  output logic                  o_tr_valid,
  input  logic                  i_tr_ready,
  output logic [2*COORD_W-1:0]  o_tr_state,
  output logic [ACT_W-1:0]      o_tr_action,
  output logic [DATA_WIDTH-1:0] o_tr_reward,
  output logic [2*COORD_W-1:0]  o_tr_next_state,
  output logic                  o_tr_wall,
  output logic                  o_tr_done,
  output logic                  o_tr_timeout,
  output logic [15:0]           o_episode_cnt
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [COORD_W-1:0] SX = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY = COORD_W'(START_Y);

  state_e                  state_q;
  logic [COORD_W-1:0]      pos_x_q, pos_y_q;
  logic [STEP_W-1:0]       step_q;
  logic [15:0]             episode_q;
  logic [ACT_W-1:0]        act_q;
  logic                    act_ready_q, rt_read_q, tr_valid_q;
  logic [ADDR_WIDTH-1:0]   rt_addr_q;
  logic [DATA_WIDTH-1:0]   reward_q;
  logic [2*COORD_W-1:0]    tr_state_q, tr_next_q;
  logic                    tr_wall_q, tr_done_q, tr_timeout_q;

  logic [COORD_W-1:0]      next_x_d, next_y_d;
  logic                    wall_d, goal_d, timeout_d, done_d;

  grid_move #(.COORD_W(COORD_W)) u_move (
    .x_i      (pos_x_q),
    .y_i      (pos_y_q),
    .action_i (act_q),
    .next_x_o (next_x_d),
    .next_y_o (next_y_d),
    .wall_o   (wall_d)
  );

  assign goal_d = (next_x_d == COORD_W'(GOAL_X)) && (next_y_d == COORD_W'(GOAL_Y));
`ifdef STEP_TIMEOUT_EN
  assign timeout_d = !goal_d && (step_q == STEP_W'(MAX_STEPS - 1));
`else
  assign timeout_d = 1'b0;
`endif
  assign done_d = goal_d | timeout_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pos_x_q      <= SX;
      pos_y_q      <= SY;
      step_q       <= '0;
      episode_q    <= '0;
      act_q        <= '0;
      act_ready_q  <= 1'b1;
      rt_read_q    <= 1'b0;
      rt_addr_q    <= '0;
      tr_valid_q   <= 1'b0;
      reward_q     <= '0;
      tr_state_q   <= '0;
      tr_next_q    <= '0;
      tr_wall_q    <= 1'b0;
      tr_done_q    <= 1'b0;
      tr_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_act_valid && act_ready_q) begin
            act_q       <= i_action;
            rt_addr_q   <= pack_addr(pos_x_q, pos_y_q, i_action);
            rt_read_q   <= 1'b1;
            act_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          rt_read_q <= 1'b0;
          state_q   <= CAP;
        end
        CAP: begin
          reward_q     <= i_rt_data;
          tr_state_q   <= {pos_x_q, pos_y_q};
          tr_next_q    <= {next_x_d, next_y_d};
          tr_wall_q    <= wall_d;
          tr_done_q    <= done_d;
          tr_timeout_q <= timeout_d;
          tr_valid_q   <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          if (i_tr_ready) begin
            tr_valid_q  <= 1'b0;
            act_ready_q <= 1'b1;
            state_q     <= IDLE;
            if (tr_done_q) begin
              pos_x_q   <= SX;
              pos_y_q   <= SY;
              step_q    <= '0;
              episode_q <= episode_q + 16'd1;
            end else begin
              pos_x_q <= tr_next_q[2*COORD_W-1:COORD_W];
              pos_y_q <= tr_next_q[COORD_W-1:0];
              step_q  <= step_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_act_ready     = act_ready_q;
  assign o_rt_addr       = rt_addr_q;
  assign o_rt_read       = rt_read_q;
  assign o_tr_valid      = tr_valid_q;
  assign o_tr_state      = tr_state_q;
  assign o_tr_action     = act_q;
  assign o_tr_reward     = reward_q;
  assign o_tr_next_state = tr_next_q;
  assign o_tr_wall       = tr_wall_q;
  assign o_tr_done       = tr_done_q;
  assign o_tr_timeout    = tr_timeout_q;
  assign o_episode_cnt   = episode_q;

endmodule

// File: tb/tb_grid_env_stepper.sv
// tb/tb_grid_env_stepper.sv - table-driven scoreboard bench for grid_env_stepper
module tb_grid_env_stepper;
  import grid_env_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_act_valid = 1'b0;
  logic        o_act_ready;
  logic [2:0]  i_action = 3'd0;
  logic [8:0]  o_rt_addr;
  logic        o_rt_read;
  logic [31:0] i_rt_data = 32'h0;
  logic        o_tr_valid;
  logic        i_tr_ready = 1'b0;
  logic [5:0]  o_tr_state;
  logic [2:0]  o_tr_action;
  logic [31:0] o_tr_reward;
  logic [5:0]  o_tr_next_state;
  logic        o_tr_wall;
  logic        o_tr_done;
  logic        o_tr_timeout;
  logic [15:0] o_episode_cnt;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [2:0]  act;
    logic [8:0]  addr;
    logic [31:0] rew;
    logic [5:0]  st;
    logic [5:0]  nst;
    logic        wall;
    logic        done;
    logic        tmo;
    logic [15:0] ep;
  } rec_t;

  rec_t tab[$];
  rec_t sb[$];

  grid_env_stepper #(.MAX_STEPS(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_act_valid(i_act_valid), .o_act_ready(o_act_ready),
    .i_action(i_action), .o_rt_addr(o_rt_addr), .o_rt_read(o_rt_read), .i_rt_data(i_rt_data),
    .o_tr_valid(o_tr_valid), .i_tr_ready(i_tr_ready), .o_tr_state(o_tr_state),
    .o_tr_action(o_tr_action), .o_tr_reward(o_tr_reward), .o_tr_next_state(o_tr_next_state),
    .o_tr_wall(o_tr_wall), .o_tr_done(o_tr_done), .o_tr_timeout(o_tr_timeout),
    .o_episode_cnt(o_episode_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reward ROM stub: wall moves and the goal cell carry distinct rewards.
  function automatic logic [31:0] rom_word(input logic [8:0] a);
    int x, y, dx, dy, nx, ny;
    bit w;
    x = int'(a[8:6]); y = int'(a[5:3]);
    case (a[2:0])
      3'd0: begin dx = -1; dy =  0; end
      3'd1: begin dx = -1; dy = -1; end
      3'd2: begin dx =  0; dy = -1; end
      3'd3: begin dx =  1; dy = -1; end
      3'd4: begin dx =  1; dy =  0; end
      3'd5: begin dx =  1; dy =  1; end
      3'd6: begin dx =  0; dy =  1; end
      default: begin dx = -1; dy = 1; end
    endcase
    nx = x + dx; ny = y + dy; w = 1'b0;
    if (nx < 0 || nx > 7) begin nx = x; w = 1'b1; end
    if (ny < 0 || ny > 7) begin ny = y; w = 1'b1; end
    if (w) return R_WALL;
    if (nx == 7 && ny == 7) return R_GOAL;
    return 32'h0;
  endfunction

  always @(posedge i_clk) i_rt_data <= o_rt_read ? rom_word(o_rt_addr) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic rec_t mk(input int a, input int x, input int y, input int nx, input int ny,
                              input bit w, input bit d, input bit t, input logic [31:0] rw,
                              input int ep);
    rec_t r;
    r.act = 3'(a); r.addr = {3'(x), 3'(y), 3'(a)}; r.rew = rw;
    r.st = {3'(x), 3'(y)}; r.nst = {3'(nx), 3'(ny)};
    r.wall = w; r.done = d; r.tmo = t; r.ep = 16'(ep);
    return r;
  endfunction

  task automatic check_rec(input rec_t e);
    chk("tr_valid", o_tr_valid, 1);
    chk("tr_state", o_tr_state, e.st);
    chk("tr_action", o_tr_action, e.act);
    chk("tr_reward", o_tr_reward, e.rew);
    chk("tr_next_state", o_tr_next_state, e.nst);
    chk("tr_wall", o_tr_wall, e.wall);
    chk("tr_done", o_tr_done, e.done);
    chk("tr_timeout", o_tr_timeout, e.tmo);
  endtask

  task automatic do_step(input rec_t r, input int stall);
    int lat;
    rec_t e;
    @(negedge i_clk);
    chk("act_ready_idle", o_act_ready, 1);
    i_act_valid = 1'b1; i_action = r.act;
    sb.push_back(r);
    @(negedge i_clk);
    i_act_valid = 1'b0; i_action = 3'($urandom);
    chk("rt_read_issue", o_rt_read, 1);
    chk("rt_addr", o_rt_addr, r.addr);
    lat = 1;
    while (!o_tr_valid && lat < 8) begin
      @(negedge i_clk);
      lat++;
      if (lat == 2) chk("rt_read_cap", o_rt_read, 0);
    end
    chk("latency", lat, 3);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_rec(e);
      for (int k = 0; k < stall; k++) begin
        @(negedge i_clk);
        check_rec(e);
        chk("stall_act_ready", o_act_ready, 0);
        chk("stall_rt_read", o_rt_read, 0);
        chk("stall_rt_addr", o_rt_addr, e.addr);
      end
      i_tr_ready = 1'b1;
      @(negedge i_clk);
      i_tr_ready = 1'b0;
      chk("valid_after_hs", o_tr_valid, 0);
      chk("act_ready_after_hs", o_act_ready, 1);
      chk("episode_cnt", o_episode_cnt, e.ep);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef STEP_TIMEOUT_EN
    tab.push_back(mk(4, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, R_WALL, 0));
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, R_WALL, 1));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(5, i, i, i + 1, i + 1, 0, i == 3, i == 3, 32'h0, (i == 3) ? 2 : 1));
    tab.push_back(mk(7, 0, 0, 0, 1, 1, 0, 0, R_WALL, 2));
`else
    tab.push_back(mk(4, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, R_WALL, 0));
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, R_WALL, 0));
    for (int i = 0; i < 6; i++)
      tab.push_back(mk(5, i, i, i + 1, i + 1, 0, 0, 0, 32'h0, 0));
    tab.push_back(mk(6, 6, 6, 6, 7, 0, 0, 0, 32'h0, 0));
    tab.push_back(mk(6, 6, 7, 6, 7, 1, 0, 0, R_WALL, 0));
    tab.push_back(mk(4, 6, 7, 7, 7, 0, 1, 0, R_GOAL, 1));
    tab.push_back(mk(3, 0, 0, 1, 0, 1, 0, 0, R_WALL, 1));
`endif

    repeat (3) @(negedge i_clk);
    chk("rst_act_ready", o_act_ready, 1);
    chk("rst_tr_valid", o_tr_valid, 0);
    chk("rst_rt_read", o_rt_read, 0);
    chk("rst_rt_addr", o_rt_addr, 0);
    chk("rst_episode", o_episode_cnt, 0);
    chk("rst_fields", {o_tr_state, o_tr_action, o_tr_reward, o_tr_next_state,
                       o_tr_wall, o_tr_done, o_tr_timeout}, 0);
    i_rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++)
      do_step(tab[i], (i % 4 == 3 || tab[i].done) ? 5 : i % 3);

    // Reset while the ROM word is being captured.
    @(negedge i_clk);
    i_act_valid = 1'b1; i_action = 3'd4;
    @(negedge i_clk);
    i_act_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("cap_rst_tr_valid", o_tr_valid, 0);
    chk("cap_rst_act_ready", o_act_ready, 1);
    chk("cap_rst_rt_read", o_rt_read, 0);
    chk("cap_rst_episode", o_episode_cnt, 0);
    repeat (3) @(negedge i_clk);
    chk("cap_rst_no_record", o_tr_valid, 0);

    do_step(mk(4, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
